// File: rtl/fc_bus_pkg.sv
// Shared constants and types for the FC core-port address demultiplexer.
package fc_bus_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } fc_addr_rule_t;

    // Port IDs span 0..n_ports, where n_ports itself names the error slave.
    function automatic int port_id_w(input int n_ports);
        return $clog2(n_ports + 1);
    endfunction

endpackage

// File: rtl/fc_demux_id_fifo.sv
// Small synchronous FIFO holding the port ID of every in-flight transaction.
module fc_demux_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wptr, rptr;
    logic                        do_push, do_pop;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fc_bus_demux.sv
// Address-decoding demux from one FC core port to N downstream TCDM ports,
// with an internal error slave and in-order response return.
module fc_bus_demux
    import fc_bus_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_i,
    input  logic [ADDR_WIDTH-1:0]                add_i,
    input  logic                                 wen_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    input  logic [DATA_WIDTH/8-1:0]              be_i,
    output logic                                 gnt_o,
    output logic                                 r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   rule_start_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   rule_end_i,
    output logic [N_PORTS-1:0]                   mst_req_o,
    output logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   mst_add_o,
    output logic [N_PORTS-1:0]                   mst_wen_o,
    output logic [N_PORTS-1:0][DATA_WIDTH-1:0]   mst_wdata_o,
    output logic [N_PORTS-1:0][DATA_WIDTH/8-1:0] mst_be_o,
    input  logic [N_PORTS-1:0]                   mst_gnt_i,
    input  logic [N_PORTS-1:0]                   mst_r_valid_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   mst_r_rdata_i,
    output logic                                 busy_o,
    output logic                                 proto_err_o
);

    localparam int              ID_W   = port_id_w(N_PORTS);
    localparam int              CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ID_W-1:0] ERR_ID = ID_W'(N_PORTS);

    logic [ID_W-1:0]       sel, last_sel, head;
    logic                  full, empty, issue;
    logic                  err_q, proto_err_q;
    logic                  rsp_real, stray;
    logic [DATA_WIDTH-1:0] rdata_real;
    logic [CNT_W-1:0]      count;

    // Walk downwards so the lowest matching index is the one left in sel.
    always_comb begin
        sel = ERR_ID;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (rule_start_i[p] <= add_i && add_i < rule_end_i[p]) sel = ID_W'(p);
        end
    end

    // Only keep issuing to the port already in flight; a switch waits for a full drain.
    assign issue = req_i & ~full & (empty | (last_sel == sel));

    always_comb begin
        mst_req_o = '0;
        gnt_o     = issue & (sel == ERR_ID);
        for (int p = 0; p < N_PORTS; p++) begin
            if (sel == ID_W'(p)) begin
                mst_req_o[p] = issue;
                gnt_o        = issue & mst_gnt_i[p];
            end
        end
    end

    assign mst_add_o   = {N_PORTS{add_i}};
    assign mst_wen_o   = {N_PORTS{wen_i}};
    assign mst_wdata_o = {N_PORTS{wdata_i}};
    assign mst_be_o    = {N_PORTS{be_i}};

    // Anything valid from a port other than the FIFO head is a stray response.
    always_comb begin
        rsp_real   = 1'b0;
        rdata_real = '0;
        stray      = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!empty && head == ID_W'(p)) begin
                rsp_real   = mst_r_valid_i[p];
                rdata_real = mst_r_rdata_i[p];
            end else if (mst_r_valid_i[p]) begin
                stray = 1'b1;
            end
        end
    end

    // err_q can only be set while the error ID sits at the head, so it never
    // collides with a real-port response.
    assign r_valid_o   = rsp_real | err_q;
    assign r_rdata_o   = err_q ? DATA_WIDTH'(ERR_RDATA) : (rsp_real ? rdata_real : '0);
    assign r_opc_o     = err_q;
    assign busy_o      = (count != '0);
    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_sel    <= '0;
            err_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (gnt_o) last_sel <= sel;
            err_q       <= gnt_o & (sel == ERR_ID);
            proto_err_q <= stray;
        end
    end

    fc_demux_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (gnt_o),
        .pop   (r_valid_o),
        .wdata (sel),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_fc_bus_demux.sv
// Self-checking bench for fc_bus_demux: directed scenarios plus randomized
// traffic against an in-order response scoreboard.
module tb_fc_bus_demux;

    localparam int N = 2, AW = 32, DW = 32, BW = 4;
    localparam logic [31:0] ERR = 32'hBADACCE5;

    logic clk, rst_n, req, wen, gnt, r_valid, r_opc, busy, proto_err;
    logic [AW-1:0] add;
    logic [DW-1:0] wdata, r_rdata, inj_rdata;
    logic [BW-1:0] be;
    logic [N-1:0][AW-1:0] rule_start, rule_end, mst_add;
    logic [N-1:0] mst_req, mst_wen, mgnt, slv_valid, inj_valid, mst_r_valid;
    logic [N-1:0][DW-1:0] mst_wdata, slv_rdata, mst_r_rdata;
    logic [N-1:0][BW-1:0] mst_be;

    int n_cmp = 0, n_err = 0, cyc = 0, sb_sel;
    int lat [N];
    logic [31:0] salt [N];
    int due_q [N][$];
    logic [31:0] dat_q [N][$];
    logic [32:0] exp_q [$], obs_q [$];

    assign mst_r_valid = slv_valid | inj_valid;
    always_comb for (int p = 0; p < N; p++) mst_r_rdata[p] = inj_valid[p] ? inj_rdata : slv_rdata[p];

    fc_bus_demux #(.N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
        .rule_start_i(rule_start), .rule_end_i(rule_end),
        .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_wen_o(mst_wen), .mst_wdata_o(mst_wdata), .mst_be_o(mst_be),
        .mst_gnt_i(mgnt), .mst_r_valid_i(mst_r_valid), .mst_r_rdata_i(mst_r_rdata),
        .busy_o(busy), .proto_err_o(proto_err));

    initial begin clk = 0; forever #5 clk = ~clk; end

    // Address-decode rule: lowest-index matching half-open range, else error slave.
    function automatic int decode(input logic [31:0] a);
        for (int p = 0; p < N; p++) if (rule_start[p] <= a && a < rule_end[p]) return p;
        return N;
    endfunction

    // Downstream slaves: fixed latency per port, data = address ^ salt.
    initial forever begin
        @(posedge clk); cyc++; #1;
        for (int p = 0; p < N; p++) begin
            slv_valid[p] = 1'b0;
            if (due_q[p].size() > 0 && due_q[p][0] <= cyc) begin
                void'(due_q[p].pop_front());
                slv_valid[p] = 1'b1;
                slv_rdata[p] = dat_q[p].pop_front();
            end
        end
    end

    // Slave acceptance and the in-order scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        for (int p = 0; p < N; p++)
            if (mst_req[p] && mgnt[p]) begin
                due_q[p].push_back(cyc + lat[p]);
                dat_q[p].push_back(mst_add[p] ^ salt[p]);
            end
        if (req && gnt) begin
            sb_sel = decode(add);
            exp_q.push_back(sb_sel == N ? {1'b1, ERR} : {1'b0, add ^ salt[sb_sel]});
        end
        if (r_valid) obs_q.push_back({r_opc, r_rdata});
    end

    initial begin #2000000; $display("FAIL timeout: simulation did not finish"); $fatal(1); end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic test_reset();
        rst_n = 0; req = 0; repeat (2) step(); #3;
        n_cmp++; if ({gnt, r_valid, r_opc, busy, proto_err} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {gnt, r_valid, r_opc, busy, proto_err}); end
        n_cmp++; if (mst_req !== 2'b00) begin n_err++; $display("FAIL reset_mst_req: got %b want 00", mst_req); end
        n_cmp++; if (r_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", r_rdata); end
        step(); rst_n = 1;
    endtask

    task automatic test_decode();
        lat[0] = 1; salt[0] = 32'h12345678 ^ 32'h1C000010;
        step(); req = 1; add = 32'h1C000010; wen = 1; #3;
        n_cmp++; if (mst_req !== 2'b01) begin n_err++; $display("FAIL dec_mst_req: got %b want 01", mst_req); end
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL dec_gnt: got %b want 1", gnt); end
        n_cmp++; if (mst_add[0] !== 32'h1C000010) begin n_err++; $display("FAIL dec_add: got %h want 1c000010", mst_add[0]); end
        step(); req = 0; #3;
        n_cmp++; if ({r_valid, r_opc} !== 2'b10) begin n_err++; $display("FAIL dec_rsp: got valid/opc %b want 10", {r_valid, r_opc}); end
        n_cmp++; if (r_rdata !== 32'h12345678) begin n_err++; $display("FAIL dec_rdata: got %h want 12345678", r_rdata); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dec_busy: got %b want 1", busy); end
        step(); #3;
        n_cmp++; if ({busy, r_valid} !== 2'b00) begin n_err++; $display("FAIL dec_idle: got busy/valid %b want 00", {busy, r_valid}); end
    endtask

    task automatic test_error();
        step(); req = 1; add = 32'h0; #3;
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL err_gnt0: got %b want 1", gnt); end
        n_cmp++; if (mst_req !== 2'b00 || r_valid !== 1'b0) begin n_err++; $display("FAIL err_noreq: got req %b valid %b want 00 0", mst_req, r_valid); end
        for (int i = 1; i <= 3; i++) begin
            step(); req = (i < 3); #3;
            if (i < 3) begin n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL err_gnt%0d: got %b want 1", i, gnt); end end
            n_cmp++; if ({r_valid, r_opc, r_rdata} !== {2'b11, ERR}) begin n_err++; $display("FAIL err_rsp%0d: got v%b o%b %h want v1 o1 %h", i, r_valid, r_opc, r_rdata, ERR); end
        end
        step(); #3;
        n_cmp++; if ({r_valid, busy} !== 2'b00) begin n_err++; $display("FAIL err_idle: got valid/busy %b want 00", {r_valid, busy}); end
    endtask

    task automatic test_switch();
        lat[0] = 3; lat[1] = 1; salt[0] = 32'h0F0F0000; salt[1] = 32'h00FF00FF;
        step(); req = 1; add = 32'h1C000020; #3;
        n_cmp++; if (gnt !== 1'b1 || mst_req !== 2'b01) begin n_err++; $display("FAIL sw_first: got gnt %b req %b want 1 01", gnt, mst_req); end
        for (int k = 1; k <= 5; k++) begin
            step(); if (k == 1) add = 32'h1A000040; if (k == 5) req = 0; #3;
            if (k <= 3) begin n_cmp++; if (mst_req !== 2'b00 || gnt !== 1'b0) begin n_err++; $display("FAIL sw_hold%0d: got req %b gnt %b want 00 0", k, mst_req, gnt); end end
            if (k == 3) begin n_cmp++; if (!r_valid || r_rdata !== (32'h1C000020 ^ 32'h0F0F0000)) begin n_err++; $display("FAIL sw_rsp0: got v%b %h want v1 %h", r_valid, r_rdata, 32'h1C000020 ^ 32'h0F0F0000); end end
            if (k == 4) begin n_cmp++; if (mst_req !== 2'b10 || gnt !== 1'b1 || r_valid !== 1'b0) begin n_err++; $display("FAIL sw_issue1: got req %b gnt %b v %b want 10 1 0", mst_req, gnt, r_valid); end end
            if (k == 5) begin n_cmp++; if ({r_valid, r_opc, r_rdata} !== {2'b10, 32'h1A000040 ^ 32'h00FF00FF}) begin n_err++; $display("FAIL sw_rsp1: got v%b o%b %h want v1 o0 %h", r_valid, r_opc, r_rdata, 32'h1A000040 ^ 32'h00FF00FF); end end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_g, exp_r;
        int g, r;
        exp_g = 13'b0000001100011; exp_r = 13'b0011000110000; g = 0; r = 0;
        lat[0] = 4; salt[0] = $urandom;
        for (int k = 0; k <= 12; k++) begin
            step(); req = (g < 4); add = 32'h1C000100 + 32'(g * 4); #3;
            n_cmp++; if (gnt !== exp_g[k]) begin n_err++; $display("FAIL b2b_gnt c%0d: got %b want %b", k, gnt, exp_g[k]); end
            n_cmp++; if (r_valid !== exp_r[k]) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", k, r_valid, exp_r[k]); end
            if (r_valid) begin
                n_cmp++; if (r_rdata !== ((32'h1C000100 + 32'(r * 4)) ^ salt[0])) begin n_err++; $display("FAIL b2b_rdata %0d: got %h want %h", r, r_rdata, (32'h1C000100 + 32'(r * 4)) ^ salt[0]); end
                r++;
            end
            if (k == 10) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy10: got %b want 1", busy); end end
            if (k == 11) begin n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy11: got %b want 0", busy); end end
            if (gnt) g++;
        end
        n_cmp++; if (r != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", r); end
    endtask

    task automatic test_proto_err();
        lat[0] = 3; salt[0] = 32'h55AA0000;
        step(); req = 1; add = 32'h1C000200; #3;
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL pe_gnt: got %b want 1", gnt); end
        step(); req = 0; inj_valid = 2'b10; inj_rdata = 32'hDEADBEEF; #3;
        n_cmp++; if (r_valid !== 1'b0 || proto_err !== 1'b0) begin n_err++; $display("FAIL pe_inject: got v%b pe%b want 0 0", r_valid, proto_err); end
        step(); inj_valid = 2'b00; #3;
        n_cmp++; if ({proto_err, busy, r_valid} !== 3'b110) begin n_err++; $display("FAIL pe_pulse: got pe/busy/v %b want 110", {proto_err, busy, r_valid}); end
        step(); #3;
        n_cmp++; if (proto_err !== 1'b0 || !r_valid || r_rdata !== (32'h1C000200 ^ 32'h55AA0000)) begin n_err++; $display("FAIL pe_resp: got pe%b v%b %h want 0 1 %h", proto_err, r_valid, r_rdata, 32'h1C000200 ^ 32'h55AA0000); end
        step(); inj_valid = 2'b01; #3;
        n_cmp++; if (busy !== 1'b0 || r_valid !== 1'b0) begin n_err++; $display("FAIL pe_empty_v: got busy%b v%b want 0 0", busy, r_valid); end
        step(); inj_valid = 2'b00; #3;
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL pe_empty: got %b want 1", proto_err); end
        step();
    endtask

    task automatic test_reset_midflight();
        lat[0] = 4; salt[0] = $urandom;
        step(); req = 1; add = 32'h1C000300; #3;
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL rm_gnt0: got %b want 1", gnt); end
        step(); add = 32'h1C000304; #3;
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL rm_gnt1: got %b want 1", gnt); end
        step(); req = 0; rst_n = 0; #3;
        step(); rst_n = 1; #3;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        step(); #3;
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rm_late0_v: got %b want 0", r_valid); end
        for (int k = 5; k <= 6; k++) begin
            step(); #3;
            n_cmp++; if (proto_err !== 1'b1 || r_valid !== 1'b0) begin n_err++; $display("FAIL rm_late c%0d: got pe%b v%b want 1 0", k, proto_err, r_valid); end
        end
        step(); lat[0] = 1; req = 1; add = 32'h1C000308; #3;
        n_cmp++; if (gnt !== 1'b1 || mst_req !== 2'b01) begin n_err++; $display("FAIL rm_new: got gnt %b req %b want 1 01", gnt, mst_req); end
        step(); req = 0; #3;
        n_cmp++; if (!r_valid || r_rdata !== (32'h1C000308 ^ salt[0])) begin n_err++; $display("FAIL rm_new_rsp: got v%b %h want 1 %h", r_valid, r_rdata, 32'h1C000308 ^ salt[0]); end
        step();
    endtask

    task automatic test_random();
        logic [31:0] cand [8];
        int s;
        for (int ph = 0; ph < 3; ph++) begin
            // Phase 1: port 1 rule inverted (never matches); phase 2: port 1 overlaps port 0.
            if (ph == 1) begin rule_start[1] = 32'h1A100000; rule_end[1] = 32'h1A000000; end
            if (ph == 2) begin rule_start[1] = 32'h1C000000; rule_end[1] = 32'h1C100000; end
            cand = '{32'h1C000000, 32'h1C07FFFC, 32'h1C080000, 32'h1A000000, 32'h1A0FFFFC, 32'h1A100000, 32'h0, 32'h0};
            for (int p = 0; p < N; p++) begin lat[p] = $urandom_range(1, 3); salt[p] = $urandom; end
            exp_q.delete(); obs_q.delete();
            for (int i = 0; i < 150; i++) begin
                step();
                cand[7] = $urandom;
                req = ($urandom_range(0, 3) != 0); add = cand[$urandom_range(0, 7)];
                wen = 1'($urandom); wdata = $urandom; be = 4'($urandom); mgnt = 2'($urandom);
                #3;
                s = decode(add);
                n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rnd_proto ph%0d c%0d: got %b want 0", ph, i, proto_err); end
                if (!req) begin n_cmp++; if (gnt !== 1'b0 || mst_req !== 2'b00) begin n_err++; $display("FAIL rnd_idle ph%0d c%0d: got gnt %b req %b want 0 00", ph, i, gnt, mst_req); end end
                if (req && gnt) begin
                    n_cmp++;
                    if (mst_req !== (s < N ? 2'(1 << s) : 2'b00)) begin n_err++; $display("FAIL rnd_sel ph%0d c%0d: addr %h got req %b want port %0d", ph, i, add, mst_req, s); end
                end
                n_cmp++; if (mst_add[1] !== add || mst_wdata[1] !== wdata || mst_be[0] !== be || mst_wen !== {2{wen}}) begin n_err++; $display("FAIL rnd_bcast ph%0d c%0d: got %h %h %h %b", ph, i, mst_add[1], mst_wdata[1], mst_be[0], mst_wen); end
            end
            step(); req = 0; mgnt = '1; #3;
            for (int w = 0; w < 40 && !(busy == 1'b0 && obs_q.size() == exp_q.size()); w++) begin step(); #3; end
            n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin n_err++; $display("FAIL rnd_count ph%0d: got %0d responses want %0d", ph, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_rsp ph%0d #%0d: got opc/data %h want %h", ph, i, obs_q[i], exp_q[i]); end
            end
        end
        rule_start[1] = 32'h1A000000; rule_end[1] = 32'h1A100000;
    endtask

    initial begin
        rst_n = 0; req = 0; add = '0; wen = 0; wdata = '0; be = '0; mgnt = '1;
        slv_valid = '0; slv_rdata = '0; inj_valid = '0; inj_rdata = '0;
        rule_start[0] = 32'h1C000000; rule_end[0] = 32'h1C080000;
        rule_start[1] = 32'h1A000000; rule_end[1] = 32'h1A100000;
        lat = '{1, 1}; salt = '{32'h0, 32'h0};
        test_reset();
        test_decode();
        test_error();
        test_switch();
        test_back_to_back();
        test_proto_err();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
